pc_stack_unit: RTL and testbench

Parametrised program counter with an integrated return-address stack: the next-generation replacement for the 16-bit increment/load PC. It adds relative branch, skip, and call/return. Configurable address width, stack depth and reset vector. It sits between the control unit, which drives `op`/`pc_enable`, and the shared data bus. `out` feeds instruction memory addressing.

---
 rtl/pc_stack_unit.sv | 108 ++++++++++
 tb/tb_pc_stack_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// Program counter with an integrated LIFO return-address stack.
// Supports increment, jump, relative branch, skip, and call/return.
module pc_stack_unit #(
  parameter int unsigned     WIDTH        = 16,
  parameter int unsigned     DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pc_enable,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         bus,
  output logic [WIDTH-1:0]         out,
  output logic [WIDTH-1:0]         tos,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     stack_full,
  output logic                     stack_empty,
  output logic                     stack_error
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = AW + 1;

  localparam logic [2:0] OP_INC    = 3'd0;
  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;
  localparam logic [2:0] OP_SKIP   = 3'd5;

  logic [WIDTH-1:0] out_q, out_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic             push;
  logic [WIDTH-1:0] ret_addr;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;

  assign stack_full  = (depth_q == DW'(DEPTH));
  assign stack_empty = (depth_q == '0);
  assign top_idx     = AW'(depth_q - DW'(1));
  assign wr_idx      = AW'(depth_q);
  assign ret_addr    = out_q + WIDTH'(1);

  // tos reads as zero when empty so stale stack contents never leak out
  assign tos = stack_empty ? '0 : stack_q[top_idx];

  always_comb begin
    out_d   = out_q;
    depth_d = depth_q;
    err_d   = err_q;
    push    = 1'b0;
    if (pc_enable) begin
      case (op)
        OP_INC:    out_d = ret_addr;
        OP_JUMP:   out_d = bus;
        // bus is already WIDTH bits, so modular addition is the sign-extended add
        OP_BRANCH: out_d = out_q + bus;
        OP_CALL: begin
          if (stack_full) begin
            out_d = ret_addr;
            err_d = 1'b1;
          end else begin
            push    = 1'b1;
            out_d   = bus;
            depth_d = depth_q + DW'(1);
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            out_d = ret_addr;
            err_d = 1'b1;
          end else begin
            out_d   = tos;
            depth_d = depth_q - DW'(1);
          end
        end
        OP_SKIP:   out_d = out_q + WIDTH'(2);
        default:   out_d = out_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= RESET_VECTOR;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack storage needs no reset: entries above depth are never observable
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      stack_q[wr_idx] <= ret_addr;
    end
  end

  assign out         = out_q;
  assign depth       = depth_q;
  assign stack_error = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios plus random
// stimulus compared against a queue-based reference model.
module tb_pc_stack_unit;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  logic         clk;
  logic         rst;
  logic         pc_enable;
  logic [2:0]   op;
  logic [W-1:0] bus;
  logic [W-1:0] out;
  logic [W-1:0] tos;
  logic [2:0]   depth;
  logic         stack_full;
  logic         stack_empty;
  logic         stack_error;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk[$];
  logic         m_err;

  pc_stack_unit #(.WIDTH(W), .DEPTH(D), .RESET_VECTOR(16'h0000)) dut (
    .clk(clk), .rst(rst), .pc_enable(pc_enable), .op(op), .bus(bus),
    .out(out), .tos(tos), .depth(depth), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_error(stack_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit e, input logic [2:0] o, input logic [W-1:0] b);
    if (r) begin
      m_pc = '0;
      m_stk.delete();
      m_err = 1'b0;
    end else if (e) begin
      case (o)
        3'd0: m_pc = W'(m_pc + 1);
        3'd1: m_pc = b;
        3'd2: m_pc = W'(m_pc + b);
        3'd3: begin
          if (m_stk.size() == D) begin
            m_pc  = W'(m_pc + 1);
            m_err = 1'b1;
          end else begin
            m_stk.push_back(W'(m_pc + 1));
            m_pc = b;
          end
        end
        3'd4: begin
          if (m_stk.size() == 0) begin
            m_pc  = W'(m_pc + 1);
            m_err = 1'b1;
          end else begin
            m_pc = m_stk.pop_back();
          end
        end
        3'd5: m_pc = W'(m_pc + 2);
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    logic [W-1:0] exp_tos;
    exp_tos = (m_stk.size() == 0) ? '0 : m_stk[$];
    chk("out", 32'(out), 32'(m_pc));
    chk("depth", 32'(depth), 32'(m_stk.size()));
    chk("tos", 32'(tos), 32'(exp_tos));
    chk("full", 32'(stack_full), 32'(m_stk.size() == D));
    chk("empty", 32'(stack_empty), 32'(m_stk.size() == 0));
    chk("error", 32'(stack_error), 32'(m_err));
  endtask

  // Apply one cycle of stimulus, advance the model, and compare after the edge
  task automatic step(input bit r, input bit e, input logic [2:0] o, input logic [W-1:0] b);
    rst = r; pc_enable = e; op = o; bus = b;
    @(posedge clk);
    model_update(r, e, o, b);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; pc_enable = 1'b0; op = '0; bus = '0;
    m_pc = '0; m_err = 1'b0;

    // Reset, increment, hold
    step(1, 0, 3'd0, '0);
    chk("rst_out", 32'(out), 32'h0);
    repeat (3) step(0, 1, 3'd0, '0);
    step(0, 0, 3'd1, 16'hABCD);
    step(0, 0, 3'd3, 16'h1234);
    chk("hold_out", 32'(out), 32'h3);

    // Jump and branch
    step(0, 1, 3'd1, 16'h0100);
    step(0, 1, 3'd2, 16'hFFFE);
    chk("branch_neg", 32'(out), 32'h00FE);
    step(0, 1, 3'd2, 16'h0010);
    chk("branch_pos", 32'(out), 32'h010E);

    // Wrap-around
    step(0, 1, 3'd1, 16'hFFFF); step(0, 1, 3'd0, '0);
    chk("wrap_inc", 32'(out), 32'h0000);
    step(0, 1, 3'd1, 16'hFFFF); step(0, 1, 3'd5, '0);
    chk("wrap_skip", 32'(out), 32'h0001);
    step(0, 1, 3'd1, 16'h0000); step(0, 1, 3'd2, 16'hFFFF);
    chk("wrap_branch", 32'(out), 32'hFFFF);

    // Nested call/return
    step(0, 1, 3'd1, 16'h0010);
    step(0, 1, 3'd3, 16'h0200);
    chk("call1_tos", 32'(tos), 32'h0011);
    step(0, 1, 3'd3, 16'h0300);
    chk("call2_tos", 32'(tos), 32'h0201);
    step(0, 1, 3'd4, '0);
    chk("ret1_out", 32'(out), 32'h0201);
    step(0, 1, 3'd4, '0);
    chk("ret2_out", 32'(out), 32'h0011);

    // Overflow
    for (int i = 0; i < 4; i++) step(0, 1, 3'd3, 16'(16'h0400 + i * 16));
    step(0, 1, 3'd3, 16'h0800);
    chk("ovf_out", 32'(out), 32'h0431);
    chk("ovf_err", 32'(stack_error), 32'h1);
    step(0, 1, 3'd4, '0);
    chk("ovf_ret_out", 32'(out), 32'h0421);
    chk("ovf_sticky", 32'(stack_error), 32'h1);

    // Underflow, then reset mid-operation
    step(1, 0, 3'd0, '0);
    step(0, 1, 3'd1, 16'h0005);
    step(0, 1, 3'd4, '0);
    chk("unf_out", 32'(out), 32'h0006);
    chk("unf_err", 32'(stack_error), 32'h1);
    step(0, 1, 3'd3, 16'h0040);
    step(0, 1, 3'd3, 16'h0050);
    step(1, 1, 3'd3, 16'h0060);
    chk("rst_tos", 32'(tos), 32'h0);
    chk("rst_err", 32'(stack_error), 32'h0);

    // Randomized operation mix
    for (int i = 0; i < 600; i++) begin
      bit       r, e;
      logic [2:0] o;
      logic [W-1:0] b;
      r = ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 99) < 85);
      o = 3'($urandom_range(0, 7));
      b = 16'($urandom);
      step(r, e, o, b);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
